// File: rtl/pooling_window_buffer.sv
// pooling_window_buffer
// Streaming front end of the pooling stage. Pixels arrive one per handshake in
// raster order. Even rows are parked in a one-row line buffer; odd rows pair
// with it to form 2x2, stride-2 windows. Windows collect in a staging group of
// POOLING_UNITS slots. When the last slot fills, the whole group is presented
// on win_out in one step, which lets the downstream pooling units work in
// lockstep.
module pooling_window_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int POOLING_UNITS = 4,
    parameter int IMG_WIDTH     = 8,
    parameter int IMG_HEIGHT    = 8
) (
    input  logic                                          clk,
    input  logic                                          nrst,
    input  logic                                          clr,
    input  logic [DATA_WIDTH-1:0]                         pix_in,
    input  logic                                          pix_valid,
    output logic                                          pix_ready,
    output logic [POOLING_UNITS-1:0][3:0][DATA_WIDTH-1:0] win_out,
    output logic                                          win_valid,
    input  logic                                          win_ready,
    output logic                                          win_last
);

    localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int UNIT_W = (POOLING_UNITS > 1) ? $clog2(POOLING_UNITS) : 1;

    // Position of the next pixel to arrive within the frame
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Upper row of the current window pair, plus the bottom-left pixel that
    // waits one beat for its bottom-right neighbour
    logic [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] hold;

    // Windows completed so far in the group being assembled
    logic [POOLING_UNITS-1:0][3:0][DATA_WIDTH-1:0] staging;
    logic [POOLING_UNITS-1:0][3:0][DATA_WIDTH-1:0] group_next;
    logic [3:0][DATA_WIDTH-1:0]                    new_window;

    logic              accept;
    logic              odd_row;
    logic              odd_col;
    logic              col_end;
    logic              row_end;
    logic              frame_end;
    logic              win_write;
    logic              group_load;
    logic [UNIT_W-1:0] unit_idx;
    logic [COL_W-1:0]  col_left;

    // Handshake, position decode and the window/group being formed this beat.
    // The whole block stalls while an output group is waiting, so a group load
    // can only coincide with the consumer taking the previous one.
    always_comb begin
        pix_ready  = !(win_valid && !win_ready);
        accept     = pix_valid && pix_ready;
        odd_row    = row[0];
        odd_col    = col[0];
        col_end    = (col == COL_W'(IMG_WIDTH - 1));
        row_end    = (row == ROW_W'(IMG_HEIGHT - 1));
        frame_end  = col_end && row_end;
        win_write  = accept && odd_row && odd_col;
        unit_idx   = UNIT_W'((32'(col) >> 1) % POOLING_UNITS);
        group_load = win_write && (unit_idx == UNIT_W'(POOLING_UNITS - 1));
        col_left   = col & ~(COL_W'(1));
        new_window = {pix_in, hold, line_buf[col], line_buf[col_left]};
        group_next = staging;
        group_next[unit_idx] = new_window;
    end

    // Line buffer and hold register carry no reset; every entry is rewritten
    // before it is read in each row pair
    always_ff @(posedge clk) begin
        if (accept && !clr && !odd_row) begin
            line_buf[col] <= pix_in;
        end
        if (accept && !clr && odd_row && !odd_col) begin
            hold <= pix_in;
        end
    end

    // Raster position counters; frames follow one another with no gap
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Staging slots collect each finished window at its unit position
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            staging <= '0;
        end else if (clr) begin
            staging <= '0;
        end else if (win_write) begin
            staging <= group_next;
        end
    end

    // Output group register: loads when the last slot fills, holds while the
    // consumer stalls, and clears once taken unless a new group loads instead
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            win_out   <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (clr) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (group_load) begin
            win_out   <= group_next;
            win_valid <= 1'b1;
            win_last  <= frame_end;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pooling_window_buffer.sv
// tb_pooling_window_buffer
// Directed bench for pooling_window_buffer. One instance uses a two-row frame
// (single group per frame), the other a four-row frame for back-to-back frames.
module tb_pooling_window_buffer;

    logic clk;
    logic nrst;
    logic clr;

    logic [7:0]            pix_in2;
    logic                  pix_valid2;
    logic                  pix_ready2;
    logic [3:0][3:0][7:0]  win_out2;
    logic                  win_valid2;
    logic                  win_ready2;
    logic                  win_last2;

    logic [7:0]            pix_in4;
    logic                  pix_valid4;
    logic                  pix_ready4;
    logic [3:0][3:0][7:0]  win_out4;
    logic                  win_valid4;
    logic                  win_ready4;
    logic                  win_last4;

    int vectors;
    int miscompares;
    int vcnt2;

    logic [127:0] grp2[$];
    logic         last2[$];
    logic [127:0] grp4[$];
    logic         last4[$];

    pooling_window_buffer #(
        .DATA_WIDTH(8), .POOLING_UNITS(4), .IMG_WIDTH(8), .IMG_HEIGHT(2)
    ) dut2 (
        .clk(clk), .nrst(nrst), .clr(clr),
        .pix_in(pix_in2), .pix_valid(pix_valid2), .pix_ready(pix_ready2),
        .win_out(win_out2), .win_valid(win_valid2), .win_ready(win_ready2),
        .win_last(win_last2)
    );

    pooling_window_buffer #(
        .DATA_WIDTH(8), .POOLING_UNITS(4), .IMG_WIDTH(8), .IMG_HEIGHT(4)
    ) dut4 (
        .clk(clk), .nrst(nrst), .clr(1'b0),
        .pix_in(pix_in4), .pix_valid(pix_valid4), .pix_ready(pix_ready4),
        .win_out(win_out4), .win_valid(win_valid4), .win_ready(win_ready4),
        .win_last(win_last4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every group transfer and every cycle a group is on offer
    always @(negedge clk) begin
        if (win_valid2) vcnt2++;
        if (win_valid2 && win_ready2) begin
            grp2.push_back(win_out2);
            last2.push_back(win_last2);
        end
        if (win_valid4 && win_ready4) begin
            grp4.push_back(win_out4);
            last4.push_back(win_last4);
        end
    end

    // Group for a two-row band whose top-left pixel value is base, width 8
    function automatic logic [127:0] expGroup(input int base);
        logic [3:0][3:0][7:0] g;
        for (int u = 0; u < 4; u++) begin
            g[u][0] = 8'(base + 2 * u);
            g[u][1] = 8'(base + 2 * u + 1);
            g[u][2] = 8'(base + 8 + 2 * u);
            g[u][3] = 8'(base + 9 + 2 * u);
        end
        return g;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream consecutive pixel values, one per clock; caller keeps win_ready
    // high so every beat is accepted
    task automatic applyStimulus(input int sel, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            if (sel == 2) begin
                pix_in2 = 8'(first + i);
                pix_valid2 = 1'b1;
            end else begin
                pix_in4 = 8'(first + i);
                pix_valid4 = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        pix_valid2 = 1'b0;
        pix_valid4 = 1'b0;
    endtask

    task automatic clearMonitor();
        grp2.delete();
        last2.delete();
        grp4.delete();
        last4.delete();
        vcnt2 = 0;
    endtask

    initial begin
        logic [3:0][3:0][7:0] g;
        logic [7:0] mx;

        vectors = 0;
        miscompares = 0;
        vcnt2 = 0;
        nrst = 1'b0;
        clr = 1'b0;
        pix_in2 = '0; pix_valid2 = 1'b0; win_ready2 = 1'b1;
        pix_in4 = '0; pix_valid4 = 1'b0; win_ready4 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_win_valid", win_valid2, 1'b0);
        checkOutput("rst_win_last", win_last2, 1'b0);
        checkOutput("rst_win_out", win_out2, '0);
        checkOutput("rst_pix_ready", pix_ready2, 1'b1);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        clearMonitor();

        // Single frame W=8 H=2, consumer always ready
        applyStimulus(2, 0, 15);
        checkOutput("s1_valid_before_last", win_valid2, 1'b0);
        pix_in2 = 8'd15;
        pix_valid2 = 1'b1;
        @(posedge clk);
        #1;
        pix_valid2 = 1'b0;
        checkOutput("s1_latency_valid", win_valid2, 1'b1);
        checkOutput("s1_win_out", win_out2, expGroup(0));
        checkOutput("s1_win_last", win_last2, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("s1_valid_pulse_end", win_valid2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("s1_group_count", grp2.size(), 1);
        checkOutput("s1_valid_cycles", vcnt2, 1);
        if (grp2.size() >= 1) begin
            g = grp2[0];
            for (int u = 0; u < 4; u++) begin
                mx = g[u][0];
                for (int e = 1; e < 4; e++) if (g[u][e] > mx) mx = g[u][e];
                checkOutput($sformatf("pool_max_u%0d", u), mx, 8'(9 + 2 * u));
            end
        end
        clearMonitor();

        // Same stream with the consumer stalled for five cycles
        win_ready2 = 1'b0;
        applyStimulus(2, 0, 16);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("st_valid_%0d", k), win_valid2, 1'b1);
            checkOutput($sformatf("st_pix_ready_%0d", k), pix_ready2, 1'b0);
            checkOutput($sformatf("st_win_out_%0d", k), win_out2, expGroup(0));
            @(posedge clk);
            #1;
        end
        win_ready2 = 1'b1;
        #1;
        checkOutput("st_pix_ready_on_take", pix_ready2, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("st_valid_after_take", win_valid2, 1'b0);
        checkOutput("st_pix_ready_after", pix_ready2, 1'b1);
        checkOutput("st_group_count", grp2.size(), 1);
        if (grp2.size() >= 1) checkOutput("st_group_data", grp2[0], expGroup(0));
        clearMonitor();

        // Abort a partial frame with clr, then run a fresh frame
        applyStimulus(2, 100, 11);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_no_group", vcnt2, 0);
        applyStimulus(2, 0, 16);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("clr_group_count", grp2.size(), 1);
        if (grp2.size() >= 1) begin
            checkOutput("clr_group_data", grp2[0], expGroup(0));
            checkOutput("clr_group_last", last2[0], 1'b1);
        end
        clearMonitor();

        // Asynchronous reset while a group is pending
        win_ready2 = 1'b0;
        applyStimulus(2, 50, 16);
        checkOutput("ar_pending", win_valid2, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("ar_win_valid", win_valid2, 1'b0);
        checkOutput("ar_win_last", win_last2, 1'b0);
        checkOutput("ar_win_out", win_out2, '0);
        nrst = 1'b1;
        win_ready2 = 1'b1;
        @(posedge clk);
        #1;
        clearMonitor();
        applyStimulus(2, 0, 16);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ar_group_count", grp2.size(), 1);
        if (grp2.size() >= 1) checkOutput("ar_group_data", grp2[0], expGroup(0));
        clearMonitor();

        // Two back-to-back frames on the four-row instance
        applyStimulus(4, 0, 64);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("h4_group_count", grp4.size(), 4);
        if (grp4.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("h4_group_%0d", k), grp4[k], expGroup(16 * k));
                checkOutput($sformatf("h4_last_%0d", k), last4[k], (k % 2) == 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
